slave_out: RTL and testbench

Slave-side serial read transmitter on the system bus. On a read request it takes parallel words from the slave's local storage and shifts them onto the single-bit `tx_data` line LSB-first, qualified by `slave_valid`, for the master's serial receiver. A burst of `burst_num+1` words is sent back-to-back, stalling bit by bit on `master_ready`; `tx_done` pulses when the burst completes.

---
 rtl/slave_out_if.sv | 26 ++
 rtl/slave_out.sv | 129 ++++++++++++
 tb/tb_slave_out.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/slave_out_if.sv
// Bus bundle between the slave read controller and the serial read transmitter.
// The slave modport is the transmitter side; master is the controller/storage side.
interface slave_out_if #(
  parameter int DATA_LEN  = 8,
  parameter int BURST_LEN = 13
);
  logic                 read_en;
  logic                 master_ready;
  logic [BURST_LEN-1:0] burst_num;
  logic [DATA_LEN-1:0]  tx_word;
  logic                 tx_data;
  logic                 slave_valid;
  logic                 word_req;
  logic                 tx_done;
  logic                 busy;

  modport slave (
    input  read_en, master_ready, burst_num, tx_word,
    output tx_data, slave_valid, word_req, tx_done, busy
  );

  modport master (
    output read_en, master_ready, burst_num, tx_word,
    input  tx_data, slave_valid, word_req, tx_done, busy
  );
endinterface

// File: rtl/slave_out.sv
// Serial read transmitter: shifts bursts of parallel words out LSB-first,
// one bit per accepted handshake, with every output registered.
module slave_out #(
  parameter int DATA_LEN  = 8,
  parameter int BURST_LEN = 13
) (
  input  logic        clk,
  input  logic        reset,
  slave_out_if.slave  bus
);

  localparam int BIT_W = (DATA_LEN > 1) ? $clog2(DATA_LEN) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_LEN - 1);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t               state, state_n;
  logic [DATA_LEN-1:0]  shift_q, shift_n;
  logic [BIT_W-1:0]     bit_cnt, bit_cnt_n;
  logic [BURST_LEN-1:0] word_cnt, word_cnt_n;
  logic [BURST_LEN-1:0] burst_lat, burst_lat_n;
  logic                 tx_data_q, tx_data_n;
  logic                 valid_q, valid_n;
  logic                 word_req_q, word_req_n;
  logic                 tx_done_q, tx_done_n;
  logic                 busy_q, busy_n;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      shift_q    <= '0;
      bit_cnt    <= '0;
      word_cnt   <= '0;
      burst_lat  <= '0;
      tx_data_q  <= 1'b0;
      valid_q    <= 1'b0;
      word_req_q <= 1'b0;
      tx_done_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state      <= state_n;
      shift_q    <= shift_n;
      bit_cnt    <= bit_cnt_n;
      word_cnt   <= word_cnt_n;
      burst_lat  <= burst_lat_n;
      tx_data_q  <= tx_data_n;
      valid_q    <= valid_n;
      word_req_q <= word_req_n;
      tx_done_q  <= tx_done_n;
      busy_q     <= busy_n;
    end
  end

  always_comb begin
    state_n     = state;
    shift_n     = shift_q;
    bit_cnt_n   = bit_cnt;
    word_cnt_n  = word_cnt;
    burst_lat_n = burst_lat;
    tx_data_n   = tx_data_q;
    valid_n     = valid_q;
    word_req_n  = 1'b0;
    tx_done_n   = 1'b0;

    unique case (state)
      IDLE: begin
        valid_n   = 1'b0;
        tx_data_n = 1'b0;
        if (bus.read_en && bus.master_ready) begin
          shift_n     = bus.tx_word;
          burst_lat_n = bus.burst_num;
          word_cnt_n  = '0;
          bit_cnt_n   = '0;
          valid_n     = 1'b1;
          tx_data_n   = bus.tx_word[0];
          word_req_n  = 1'b1;
          state_n     = SEND;
        end
      end

      SEND: begin
        // Abort wins over a transfer happening on the same edge.
        if (!bus.read_en) begin
          valid_n   = 1'b0;
          tx_data_n = 1'b0;
          state_n   = IDLE;
        end else if (bus.master_ready && valid_q) begin
          if (bit_cnt != LAST_BIT) begin
            shift_n   = shift_q >> 1;
            tx_data_n = shift_q[1];
            bit_cnt_n = bit_cnt + 1'b1;
          end else if (word_cnt != burst_lat) begin
            shift_n    = bus.tx_word;
            tx_data_n  = bus.tx_word[0];
            bit_cnt_n  = '0;
            word_cnt_n = word_cnt + 1'b1;
            word_req_n = 1'b1;
          end else begin
            valid_n   = 1'b0;
            tx_data_n = 1'b0;
            tx_done_n = 1'b1;
            state_n   = DONE;
          end
        end
      end

      DONE: begin
        valid_n   = 1'b0;
        tx_data_n = 1'b0;
        state_n   = IDLE;
      end

      default: begin
        valid_n   = 1'b0;
        tx_data_n = 1'b0;
        state_n   = IDLE;
      end
    endcase

    busy_n = (state_n != IDLE);
  end

  assign bus.tx_data     = tx_data_q;
  assign bus.slave_valid = valid_q;
  assign bus.word_req    = word_req_q;
  assign bus.tx_done     = tx_done_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_slave_out.sv
// Bench for slave_out: expected serial bits are queued when words are driven
// and popped against the bits actually accepted on the line.
module tb_slave_out;

  localparam int DL = 8;
  localparam int BL = 13;

  logic clk = 1'b0;
  logic reset = 1'b0;

  slave_out_if #(.DATA_LEN(DL), .BURST_LEN(BL)) bus ();

  slave_out #(.DATA_LEN(DL), .BURST_LEN(BL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  bit          exp_q[$];
  bit          got_q[$];
  int          wr_q[$];
  logic [7:0]  word_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [7:0] w);
    for (int i = 0; i < DL; i++) exp_q.push_back(w[i]);
  endtask

  // Runs the line, feeding words on word_req, recording accepted bits and
  // event cycles; cycle 0 is the current cycle. Stops at the first tx_done.
  task automatic collect(input int budget, input int mode, input bit keep_req,
                         output int done_c, output int vld_n, output int wreq_n,
                         output bit done_busy);
    done_c = -1; vld_n = 0; wreq_n = 0; done_busy = 1'b0;
    for (int c = 0; c < budget; c++) begin
      bus.master_ready = (mode == 0) ? 1'b1 : ((c % 2) == 0);
      if (bus.slave_valid) vld_n++;
      if (bus.slave_valid && bus.master_ready) got_q.push_back(bus.tx_data);
      if (bus.word_req) begin
        wreq_n++;
        wr_q.push_back(c);
        if (word_q.size() > 0) bus.tx_word = word_q.pop_front();
      end
      if (bus.tx_done) begin
        done_c = c;
        done_busy = bus.busy;
        if (!keep_req) bus.read_en = 1'b0;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    bus.read_en = 1'b0; bus.master_ready = 1'b0; bus.burst_num = '0; bus.tx_word = '0;
    reset = 1'b0;
    tick(); tick();
    checks++; if (bus.tx_data !== 1'b0) begin errors++; $display("FAIL reset_tx_data: got %b expected 0", bus.tx_data); end
    checks++; if (bus.slave_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.slave_valid); end
    checks++; if (bus.word_req !== 1'b0) begin errors++; $display("FAIL reset_word_req: got %b expected 0", bus.word_req); end
    checks++; if (bus.tx_done !== 1'b0) begin errors++; $display("FAIL reset_tx_done: got %b expected 0", bus.tx_done); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int dc, vn, wn; bit db; bit e, g; int wc;
    exp_q.delete(); got_q.delete(); wr_q.delete(); word_q.delete();
    bus.burst_num = 13'd0; bus.tx_word = 8'hA5; push_word(8'hA5);
    bus.read_en = 1'b1; bus.master_ready = 1'b1;
    collect(40, 0, 1'b0, dc, vn, wn, db);
    checks++; if (dc !== 9) begin errors++; $display("FAIL single_done_cycle: got %0d expected 9", dc); end
    checks++; if (vn !== 8) begin errors++; $display("FAIL single_valid_cycles: got %0d expected 8", vn); end
    checks++; if (wn !== 1) begin errors++; $display("FAIL single_word_req_count: got %0d expected 1", wn); end
    wc = (wr_q.size() > 0) ? wr_q.pop_front() : -1;
    checks++; if (wc !== 1) begin errors++; $display("FAIL single_word_req_cycle: got %0d expected 1", wc); end
    checks++; if (db !== 1'b1) begin errors++; $display("FAIL single_busy_in_done: got %b expected 1", db); end
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL single_bit_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL single_bit: got %b expected %b", g, e); end
    end
    tick();
    checks++; if ({bus.tx_done, bus.busy, bus.slave_valid} !== 3'b000) begin errors++; $display("FAIL single_idle_after: got %b expected 000", {bus.tx_done, bus.busy, bus.slave_valid}); end
  endtask

  task automatic test_burst();
    int dc, vn, wn; bit db; bit e, g; int wc;
    int exp_wr[3] = '{1, 9, 17};
    exp_q.delete(); got_q.delete(); wr_q.delete(); word_q.delete();
    bus.burst_num = 13'd2; bus.tx_word = 8'h01;
    word_q.push_back(8'h80); word_q.push_back(8'hFF);
    push_word(8'h01); push_word(8'h80); push_word(8'hFF);
    bus.read_en = 1'b1; bus.master_ready = 1'b1;
    collect(80, 0, 1'b0, dc, vn, wn, db);
    checks++; if (dc !== 25) begin errors++; $display("FAIL burst_done_cycle: got %0d expected 25", dc); end
    checks++; if (vn !== 24) begin errors++; $display("FAIL burst_valid_cycles: got %0d expected 24", vn); end
    checks++; if (wn !== 3) begin errors++; $display("FAIL burst_word_req_count: got %0d expected 3", wn); end
    for (int i = 0; i < 3; i++) begin
      wc = (wr_q.size() > 0) ? wr_q.pop_front() : -1;
      checks++; if (wc !== exp_wr[i]) begin errors++; $display("FAIL burst_word_req_cycle: got %0d expected %0d", wc, exp_wr[i]); end
    end
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL burst_bit_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL burst_bit: got %b expected %b", g, e); end
    end
    tick();
    checks++; if (bus.tx_done !== 1'b0) begin errors++; $display("FAIL burst_single_done: got %b expected 0", bus.tx_done); end
  endtask

  task automatic test_backpressure();
    int dc, vn, wn; bit db; bit e, g;
    exp_q.delete(); got_q.delete(); wr_q.delete(); word_q.delete();
    bus.burst_num = 13'd0; bus.tx_word = 8'h3C; push_word(8'h3C);
    bus.read_en = 1'b1; bus.master_ready = 1'b1;
    collect(80, 1, 1'b0, dc, vn, wn, db);
    checks++; if (dc !== 17) begin errors++; $display("FAIL bp_done_cycle: got %0d expected 17", dc); end
    checks++; if (wn !== 1) begin errors++; $display("FAIL bp_word_req_count: got %0d expected 1", wn); end
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL bp_bit_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL bp_bit: got %b expected %b", g, e); end
    end
    bus.master_ready = 1'b1;
    tick();
  endtask

  task automatic test_abort();
    int dc, vn, wn; bit db; bit e, g; int done_seen;
    logic [7:0] w0;
    exp_q.delete(); got_q.delete(); wr_q.delete(); word_q.delete();
    w0 = 8'h5A;
    bus.burst_num = 13'd1; bus.tx_word = w0;
    bus.read_en = 1'b1; bus.master_ready = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++; if ({bus.slave_valid, bus.tx_data} !== {1'b1, w0[i]}) begin errors++; $display("FAIL abort_pre_bit: got %b expected %b", {bus.slave_valid, bus.tx_data}, {1'b1, w0[i]}); end
      tick();
    end
    bus.read_en = 1'b0;
    tick();
    checks++; if ({bus.slave_valid, bus.tx_data, bus.busy} !== 3'b000) begin errors++; $display("FAIL abort_idle: got %b expected 000", {bus.slave_valid, bus.tx_data, bus.busy}); end
    done_seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.tx_done || bus.slave_valid) done_seen++;
      tick();
    end
    checks++; if (done_seen !== 0) begin errors++; $display("FAIL abort_quiet: got %0d active cycles expected 0", done_seen); end
    bus.burst_num = 13'd0; bus.tx_word = 8'hC3; push_word(8'hC3);
    bus.read_en = 1'b1;
    collect(40, 0, 1'b0, dc, vn, wn, db);
    checks++; if (dc !== 9) begin errors++; $display("FAIL abort_restart_done: got %0d expected 9", dc); end
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL abort_restart_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL abort_restart_bit: got %b expected %b", g, e); end
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int active;
    exp_q.delete(); got_q.delete(); wr_q.delete(); word_q.delete();
    bus.burst_num = 13'd1; bus.tx_word = 8'h0F;
    bus.read_en = 1'b1; bus.master_ready = 1'b1;
    tick();
    bus.tx_word = 8'hF0;
    for (int i = 0; i < 9; i++) tick();
    checks++; if ({bus.slave_valid, bus.tx_data} !== 2'b10) begin errors++; $display("FAIL rst_mid_pre: got %b expected 10", {bus.slave_valid, bus.tx_data}); end
    reset = 1'b0; bus.read_en = 1'b0;
    tick();
    checks++; if ({bus.tx_data, bus.slave_valid, bus.word_req, bus.tx_done, bus.busy} !== 5'b0) begin errors++; $display("FAIL rst_mid_outputs: got %b expected 00000", {bus.tx_data, bus.slave_valid, bus.word_req, bus.tx_done, bus.busy}); end
    reset = 1'b1;
    active = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.slave_valid || bus.tx_done || bus.busy) active++;
    end
    checks++; if (active !== 0) begin errors++; $display("FAIL rst_mid_quiet: got %0d active cycles expected 0", active); end
  endtask

  task automatic test_back_to_back();
    int dc, vn, wn; bit db; bit e, g; int wc;
    exp_q.delete(); got_q.delete(); wr_q.delete(); word_q.delete();
    bus.burst_num = 13'd0; bus.tx_word = 8'h96; push_word(8'h96);
    bus.read_en = 1'b1; bus.master_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if ({bus.slave_valid, bus.busy, bus.word_req} !== 3'b000) begin errors++; $display("FAIL gate_no_start: got %b expected 000", {bus.slave_valid, bus.busy, bus.word_req}); end
    end
    collect(40, 0, 1'b1, dc, vn, wn, db);
    checks++; if (dc !== 9) begin errors++; $display("FAIL gate_done_cycle: got %0d expected 9", dc); end
    bus.tx_word = 8'h69; push_word(8'h69);
    tick();
    checks++; if ({bus.slave_valid, bus.busy} !== 2'b00) begin errors++; $display("FAIL b2b_idle_gap: got %b expected 00", {bus.slave_valid, bus.busy}); end
    tick();
    wr_q.delete();
    collect(40, 0, 1'b0, dc, vn, wn, db);
    checks++; if (dc !== 8) begin errors++; $display("FAIL b2b_done_cycle: got %0d expected 8", dc); end
    checks++; if (vn !== 8) begin errors++; $display("FAIL b2b_valid_cycles: got %0d expected 8", vn); end
    wc = (wr_q.size() > 0) ? wr_q.pop_front() : -1;
    checks++; if (wc !== 0) begin errors++; $display("FAIL b2b_word_req_cycle: got %0d expected 0", wc); end
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL b2b_bit_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL b2b_bit: got %b expected %b", g, e); end
    end
    tick(); tick();
    checks++; if ({bus.slave_valid, bus.busy} !== 2'b00) begin errors++; $display("FAIL b2b_end_idle: got %b expected 00", {bus.slave_valid, bus.busy}); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_backpressure();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
